instr_fetch: RTL and testbench

Instruction fetch stage feeding the CPU's decode/execute path. Owns the program counter, issues one-outstanding requests to instruction memory over a request/grant/response handshake, and buffers fetched words with their PCs in a 2-entry queue drained by decode via valid/ready. Supports PC redirect (branch/jump) with squash of in-flight fetches, and a level-sensitive halt that stops new fetches.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 61 ++++++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU front end.
// The instruction fetch stage and its helpers import this package.
package cpu_pkg;

  localparam int          ADDR_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          PC_STEP  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between fetch and decode.
// The head is always entry 0, so the outputs come straight from registers.
module fetch_buffer #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic [ADDR_W-1:0]  pc_reg    [2];
  logic [INSTR_W-1:0] instr_reg [2];
  logic [1:0]         count_reg;
  logic               do_pop;
  logic               do_push;
  logic [1:0]         slot_sum;
  logic               wr_slot;

  assign do_pop   = pop && (count_reg != 2'd0);
  assign do_push  = push && ((count_reg != 2'd2) || do_pop);
  // Pushed word lands just behind whatever survives this cycle's pop.
  assign slot_sum = count_reg - {1'b0, do_pop};
  assign wr_slot  = slot_sum[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_reg[i]    <= '0;
        instr_reg[i] <= '0;
      end
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      if (do_pop) begin
        pc_reg[0]    <= pc_reg[1];
        instr_reg[0] <= instr_reg[1];
      end
      if (do_push) begin
        pc_reg[wr_slot]    <= push_pc;
        instr_reg[wr_slot] <= push_instr;
      end
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != 2'd0);
  assign head_pc    = pc_reg[0];
  assign head_instr = instr_reg[0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding memory request FSM, redirect
// with squash of the in-flight response, and a 2-entry output buffer.
module instr_fetch #(
  parameter int                         ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                         INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]          RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
  parameter int                         PC_STEP  = cpu_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  import cpu_pkg::*;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
  logic              squash_reg, squash_next;

  logic [1:0]        count;
  logic              pop;
  logic              resp_push;
  logic              buf_push;
  logic [2:0]        count_post;
  logic              can_issue_now;
  logic              can_issue_post;

  assign pop        = out_valid && out_ready;
  assign resp_push  = (state_reg == WAIT) && imem_rvalid && !squash_reg;
  assign buf_push   = resp_push && !redirect_valid;
  // Occupancy as it will be after this edge; decides whether WAIT may re-issue.
  assign count_post = {1'b0, count} + {2'b00, buf_push} - {2'b00, pop};

  assign can_issue_now  = !halt && (count < 2'd2);
  assign can_issue_post = !halt && (count_post < 3'd2);

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    squash_next = squash_reg;

    case (state_reg)
      IDLE: begin
        if (can_issue_now) state_next = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          req_pc_next = pc_reg;
          pc_next     = pc_reg + ADDR_W'(PC_STEP);
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          squash_next = 1'b0;
          state_next  = can_issue_post ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A response arriving in the redirect cycle is simply discarded, so only
    // a still-pending one needs the squash flag.
    if (redirect_valid) begin
      pc_next = redirect_pc;
      if (((state_reg == WAIT) && !imem_rvalid) || ((state_reg == REQ) && imem_gnt)) begin
        squash_next = 1'b1;
        state_next  = WAIT;
      end else begin
        squash_next = 1'b0;
        state_next  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
      squash_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_pc_reg <= req_pc_next;
      squash_reg <= squash_next;
    end
  end

  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (buf_push),
    .push_pc    (req_pc_reg),
    .push_instr (imem_rdata),
    .pop        (pop),
    .count      (count),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

  assign imem_req  = (state_reg == REQ);
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign halted    = halt && (state_reg == IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small instruction-memory responder
// that returns 0xA0 + address a configurable number of cycles after grant.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [31:0] pc;
  logic        halted;

  int          errors = 0;
  int          checks = 0;

  logic        gnt_en;
  logic        pend;
  logic [31:0] paddr;
  int          pcnt;
  int          lat;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .pc             (pc),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: note a grant before the edge, then drive memory-side inputs 1ns after it.
  task automatic cycle();
    logic        granted;
    logic [31:0] gaddr;
    granted = imem_req && imem_gnt;
    gaddr   = imem_addr;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (granted) begin
      pend  = 1'b1;
      paddr = gaddr;
      pcnt  = lat;
    end
    imem_rvalid = 1'b0;
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA0 + paddr;
        pend        = 1'b0;
      end
    end
    imem_gnt = imem_req && gnt_en;
  endtask

  // Wait for the next head entry, check it, and let it pop (out_ready must be 1).
  task automatic expect_out(input logic [31:0] epc);
    int n = 0;
    while (!out_valid && n < 60) begin
      cycle();
      n++;
    end
    check($sformatf("out_valid@%h", epc), {31'b0, out_valid}, 32'd1);
    check($sformatf("out_pc@%h", epc), out_pc, epc);
    check($sformatf("out_instr@%h", epc), out_instr, 32'hA0 + epc);
    $display("pop pc=%h instr=%h", out_pc, out_instr);
    cycle();
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input string tag);
    int n = 0;
    while (!imem_req && n < 60) begin
      cycle();
      n++;
    end
    check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, a);
    $display("request addr=%h", imem_addr);
  endtask

  initial begin
    rst = 1'b0; halt = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;
    gnt_en = 1'b1; pend = 1'b0; paddr = '0; pcnt = 0; lat = 1;

    // Reset state
    cycle(); cycle();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_opc", out_pc, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_halted_hi", {31'b0, halted}, 32'd1);
    halt = 1'b0;
    #1;
    check("rst_halted_lo", {31'b0, halted}, 32'd0);

    // Best-case streaming, one-cycle latency
    rst = 1'b1;
    cycle();
    check("a_req1", {31'b0, imem_req}, 32'd1);
    check("a_addr1", imem_addr, 32'd0);
    cycle();
    check("a_pc2", pc, 32'd1);
    check("a_req2", {31'b0, imem_req}, 32'd0);
    check("a_valid2", {31'b0, out_valid}, 32'd0);
    cycle();
    check("a_valid3", {31'b0, out_valid}, 32'd1);
    check("a_opc3", out_pc, 32'd0);
    check("a_instr3", out_instr, 32'hA0);
    for (int k = 0; k < 4; k++) expect_out(32'(k));

    // Asynchronous reset mid-operation, then back-pressure fills the buffer
    rst = 1'b0;
    #1;
    check("b_async_req", {31'b0, imem_req}, 32'd0);
    check("b_async_valid", {31'b0, out_valid}, 32'd0);
    check("b_async_pc", pc, 32'd0);
    pend = 1'b0; imem_rvalid = 1'b0; lat = 2; out_ready = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    repeat (12) cycle();
    check("b_full_req", {31'b0, imem_req}, 32'd0);
    check("b_full_pc", pc, 32'd2);
    check("b_full_addr", imem_addr, 32'd2);
    check("b_full_opc", out_pc, 32'd0);
    check("b_full_instr", out_instr, 32'hA0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_DEAD;
    cycle();
    check("b_stray_opc", out_pc, 32'd0);
    check("b_stray_req", {31'b0, imem_req}, 32'd0);
    out_ready = 1'b1;
    expect_out(32'd0);
    expect_out(32'd1);
    expect_out(32'd2);

    // Redirect while waiting on the response for addr 3
    check("c_pend", {31'b0, pend}, 32'd1);
    check("c_paddr", paddr, 32'd3);
    redirect_pc = 32'h40; redirect_valid = 1'b1;
    cycle();
    check("c_pc", pc, 32'h40);
    check("c_valid", {31'b0, out_valid}, 32'd0);
    expect_out(32'h40);

    // Redirect in the same cycle as the grant for addr 5
    redirect_pc = 32'd5; redirect_valid = 1'b1;
    cycle();
    wait_req_addr(32'd5, "d_first");
    check("d_gnt", {31'b0, imem_gnt}, 32'd1);
    redirect_pc = 32'h80; redirect_valid = 1'b1;
    cycle();
    check("d_pc", pc, 32'h80);
    wait_req_addr(32'h80, "d_next");
    expect_out(32'h80);

    // Halt while a response is pending
    halt = 1'b1;
    cycle();
    check("e_halted_wait", {31'b0, halted}, 32'd0);
    cycle();
    check("e_opc", out_pc, 32'h81);
    check("e_halted", {31'b0, halted}, 32'd1);
    check("e_req", {31'b0, imem_req}, 32'd0);
    repeat (4) cycle();
    check("e_pc", pc, 32'h82);
    check("e_req_idle", {31'b0, imem_req}, 32'd0);
    check("e_empty", {31'b0, out_valid}, 32'd0);
    halt = 1'b0;
    expect_out(32'h82);

    // Halt before grant keeps the request; PC wraps past all-ones
    gnt_en = 1'b0; imem_gnt = 1'b0;
    redirect_pc = 32'hFFFF_FFFF; redirect_valid = 1'b1;
    cycle();
    cycle();
    wait_req_addr(32'hFFFF_FFFF, "f_top");
    halt = 1'b1;
    repeat (3) cycle();
    check("f_req_hold", {31'b0, imem_req}, 32'd1);
    check("f_halted_req", {31'b0, halted}, 32'd0);
    check("f_addr_hold", imem_addr, 32'hFFFF_FFFF);
    gnt_en = 1'b1; imem_gnt = imem_req;
    cycle();
    check("f_wrap_pc", pc, 32'd0);
    expect_out(32'hFFFF_FFFF);
    check("f_halted", {31'b0, halted}, 32'd1);
    check("f_req_off", {31'b0, imem_req}, 32'd0);
    halt = 1'b0;
    wait_req_addr(32'd0, "f_wrap");

    // Redirect and pop together with a full buffer: flush wins
    out_ready = 1'b0;
    repeat (12) cycle();
    check("g_full_req", {31'b0, imem_req}, 32'd0);
    check("g_full_valid", {31'b0, out_valid}, 32'd1);
    check("g_full_opc", out_pc, 32'd0);
    out_ready = 1'b1; redirect_pc = 32'h10; redirect_valid = 1'b1;
    cycle();
    check("g_flush_valid", {31'b0, out_valid}, 32'd0);
    check("g_pc", pc, 32'h10);
    expect_out(32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
